pong_game_engine: RTL and testbench

//  Parametrised Pong core: paddle movement, ball physics, scoring, serve/game-over FSM, per-pixel colour.

---
 rtl/pong_game_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
`default_nettype none
// pong_game_engine: paddles, ball physics, scoring, serve/game-over FSM and per-pixel colour.
// Optional CPU-controlled player 2 when the PONG_AI_EN macro is defined.
module pong_game_engine #(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 60,
  parameter int P1_X        = 16,
  parameter int P2_X        = 616,
  parameter int BALL_S      = 8,
  parameter int PADDLE_STEP = 8,
  parameter int BALL_DIV    = 208333,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int AI_STEP     = 3
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        start,
  output logic [2:0]  color,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [11:0] FW        = 12'(FRAME_W);
  localparam logic [11:0] FH        = 12'(FRAME_H);
  localparam logic [11:0] PW        = 12'(PADDLE_W);
  localparam logic [11:0] PH        = 12'(PADDLE_H);
  localparam logic [11:0] BS        = 12'(BALL_S);
  localparam logic [11:0] HALF_B    = 12'(BALL_S / 2);
  localparam logic [11:0] P1X       = 12'(P1_X);
  localparam logic [11:0] P2X       = 12'(P2_X);
  localparam logic [11:0] FACE_L    = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] STEP      = 12'(PADDLE_STEP);
  localparam logic [11:0] ZONE_H    = 12'(PADDLE_H / 5);
  localparam logic [11:0] PAD_MAX   = 12'(FRAME_H - PADDLE_H - 1);
  localparam logic [11:0] PAD_Y0    = 12'((FRAME_H - PADDLE_H) / 2);
  localparam logic [11:0] BALL_X0   = 12'((FRAME_W - BALL_S) / 2);
  localparam logic [11:0] BALL_Y0   = 12'((FRAME_H - BALL_S) / 2);
  localparam logic [11:0] BALL_YMAX = 12'(FRAME_H - BALL_S - 1);
  localparam logic [31:0] DIV_LAST  = 32'(BALL_DIV - 1);
  localparam logic [15:0] SRV_LAST  = 16'(SERVE_TICKS - 1);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  logic [2:0]  state;
  logic [31:0] presc;
  logic        tick;
  logic [15:0] serve_cnt;
  logic [11:0] ball_x, ball_y, pad1_y, pad2_y;
  logic [2:0]  vx, vy;
  logic        dir_right, dir_down, serve_right;

  // A step that would cross either travel limit lands exactly on it.
  function automatic logic [11:0] pad_move(input logic [11:0] py, input logic up,
                                           input logic dn, input logic [11:0] step);
    logic [11:0] r;
    r = py;
    if (up && !dn)
      r = (py <= step) ? 12'd1 : py - step;
    else if (dn && !up)
      r = (py + step >= PAD_MAX) ? PAD_MAX : py + step;
    return r;
  endfunction

  assign tick = (presc == DIV_LAST);

  logic [11:0] vx12, vy12, nx, ny, centre, pad_sel, rel, zone;
  logic        ndown, at_paddle, hit;

  always_comb begin
    vx12   = {9'd0, vx};
    vy12   = {9'd0, vy};
    nx     = dir_right ? ball_x + vx12 : ball_x - vx12;
    ny     = dir_down ? ball_y + vy12 : ball_y - vy12;
    ndown  = dir_down;
    // Upward underflow is detected before subtraction so 12-bit wrap cannot fake a bottom hit.
    if (!dir_down && (ball_y <= vy12)) begin
      ny    = 12'd1;
      ndown = 1'b1;
    end else if (dir_down && (ny > BALL_YMAX)) begin
      ny    = BALL_YMAX;
      ndown = 1'b0;
    end
    centre    = ny + HALF_B;
    pad_sel   = dir_right ? pad2_y : pad1_y;
    at_paddle = dir_right ? (nx + BS >= P2X) : (ball_x <= FACE_L + vx12);
    hit       = (centre >= pad_sel) && (centre < pad_sel + PH);
    rel       = centre - pad_sel;
    zone      = rel / ZONE_H;
  end

`ifdef PONG_AI_EN
  logic [11:0] pad2_c, ball_c, ai_next;
  logic        unused_p2;
  assign unused_p2 = p2_up ^ p2_down;

  always_comb begin
    pad2_c  = pad2_y + PH / 12'd2;
    ball_c  = ball_y + HALF_B;
    ai_next = pad2_y;
    if (ball_c > pad2_c + 12'(AI_STEP))
      ai_next = pad_move(pad2_y, 1'b0, 1'b1, 12'(AI_STEP));
    else if (pad2_c > ball_c + 12'(AI_STEP))
      ai_next = pad_move(pad2_y, 1'b1, 1'b0, 12'(AI_STEP));
  end
`endif

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      presc       <= 32'd0;
      serve_cnt   <= 16'd0;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      vx          <= 3'd4;
      vy          <= 3'd0;
      dir_right   <= 1'b1;
      dir_down    <= 1'b0;
      serve_right <= 1'b1;
      pad1_y      <= PAD_Y0;
      pad2_y      <= PAD_Y0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 2'b00;
    end else begin
      presc  <= tick ? 32'd0 : presc + 32'd1;
      pad1_y <= pad_move(pad1_y, p1_up, p1_down, STEP);
`ifdef PONG_AI_EN
      if (tick && (state == ST_SERVE || state == ST_PLAY))
        pad2_y <= ai_next;
`else
      pad2_y <= pad_move(pad2_y, p2_up, p2_down, STEP);
`endif
      case (state)
        ST_IDLE: begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
          if (start) begin
            state       <= ST_SERVE;
            serve_cnt   <= 16'd0;
            serve_right <= 1'b1;
          end
        end
        ST_SERVE: begin
          ball_x    <= BALL_X0;
          ball_y    <= BALL_Y0;
          vx        <= 3'd4;
          vy        <= 3'd0;
          dir_down  <= 1'b0;
          dir_right <= serve_right;
          if (tick) begin
            if (serve_cnt == SRV_LAST) begin
              state     <= ST_PLAY;
              serve_cnt <= 16'd0;
            end else begin
              serve_cnt <= serve_cnt + 16'd1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            ball_y   <= ny;
            dir_down <= ndown;
            ball_x   <= nx;
            if (at_paddle && hit) begin
              ball_x    <= dir_right ? P2X - BS : FACE_L;
              dir_right <= !dir_right;
              case (zone)
                12'd0:   begin vx <= 3'd2; vy <= 3'd2; dir_down <= 1'b0; end
                12'd1:   begin vx <= 3'd3; vy <= 3'd1; dir_down <= 1'b0; end
                12'd2:   begin vx <= 3'd4; vy <= 3'd0; dir_down <= 1'b0; end
                12'd3:   begin vx <= 3'd3; vy <= 3'd1; dir_down <= 1'b1; end
                default: begin vx <= 3'd2; vy <= 3'd2; dir_down <= 1'b1; end
              endcase
            end else if (at_paddle) begin
              // The next serve travels toward whoever just conceded.
              if (dir_right) begin
                score_p1    <= score_p1 + 4'd1;
                serve_right <= 1'b1;
              end else begin
                score_p2    <= score_p2 + 4'd1;
                serve_right <= 1'b0;
              end
              state <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
          if (tick) begin
            if (score_p1 == WIN) begin
              state  <= ST_OVER;
              winner <= 2'b01;
            end else if (score_p2 == WIN) begin
              state  <= ST_OVER;
              winner <= 2'b10;
            end else begin
              state     <= ST_SERVE;
              serve_cnt <= 16'd0;
            end
          end
        end
        ST_OVER: begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
          if (start) begin
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            winner      <= 2'b00;
            serve_right <= 1'b1;
            serve_cnt   <= 16'd0;
            state       <= ST_SERVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_over = (state == ST_OVER);

  logic ball_vis, ball_px, p1_px, p2_px, border, in_frame;

  always_comb begin
    ball_vis = (state != ST_POINT) && (state != ST_OVER);
    in_frame = (x < FW) && (y < FH);
    ball_px  = ball_vis && (x >= ball_x) && (x < ball_x + BS) && (y >= ball_y) && (y < ball_y + BS);
    p1_px    = (x >= P1X) && (x < P1X + PW) && (y >= pad1_y) && (y < pad1_y + PH);
    p2_px    = (x >= P2X) && (x < P2X + PW) && (y >= pad2_y) && (y < pad2_y + PH);
    border   = (x == 12'd0) || (x == FW - 12'd1) || (y == 12'd0) || (y == FH - 12'd1);
    color    = 3'b000;
    if (!in_frame)    color = 3'b000;
    else if (ball_px) color = 3'b111;
    else if (p1_px)   color = 3'b001;
    else if (p2_px)   color = 3'b100;
    else if (border)  color = 3'b010;
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_engine.sv
`default_nettype none
// tb_pong_game_engine: directed scoreboard bench for pong_game_engine (BALL_DIV=4, SERVE_TICKS=2, PADDLE_STEP=24).
module tb_pong_game_engine;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] x = 12'd0, y = 12'd0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, start = 1'b0;
  logic [2:0]  color;
  logic [3:0]  score_p1, score_p2;
  logic        game_over;
  logic [1:0]  winner;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  pong_game_engine #(
    .BALL_DIV(4), .SERVE_TICKS(2), .PADDLE_STEP(24)
  ) dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x), .y(y),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down), .start(start),
    .color(color), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // sel: 0 p1_up, 1 p1_down, 2 p2_up, 3 p2_down, 4 start
  task automatic pulse(input int sel);
    case (sel)
      0: p1_up = 1'b1;
      1: p1_down = 1'b1;
      2: p2_up = 1'b1;
      3: p2_down = 1'b1;
      default: start = 1'b1;
    endcase
    step();
    {p1_up, p1_down, p2_up, p2_down, start} = 5'b0;
  endtask

  task automatic tick_wait();
    int n;
    n = 0;
    step();
    while (dut.presc != 32'd0 && n < 16) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic probe(input string tag, input logic [11:0] px, input logic [11:0] py,
                       input logic [2:0] exp_c);
    expect_v(tag, 32'(exp_c));
    x = px;
    y = py;
    #1;
    check(32'(color));
  endtask

  initial begin
    int n;
    logic [11:0] max_seen;

    do_reset();
`ifdef PONG_AI_EN
    expect_v("ai_pad2_reset", 32'd210); check(32'(dut.pad2_y));
    pulse(4);
    pulse(2);
    expect_v("ai_p2_up_ignored", 32'd210); check(32'(dut.pad2_y));
    repeat (4) tick_wait();
    expect_v("ai_aligned_no_move", 32'd210); check(32'(dut.pad2_y));
    pulse(0);
    expect_v("ai_pad1_moves", 32'd186); check(32'(dut.pad1_y));
`else
    // Reset state
    expect_v("rst_state", 32'(ST_IDLE));   check(32'(dut.state));
    expect_v("rst_pad1", 32'd210);         check(32'(dut.pad1_y));
    expect_v("rst_pad2", 32'd210);         check(32'(dut.pad2_y));
    expect_v("rst_ball_x", 32'd316);       check(32'(dut.ball_x));
    expect_v("rst_ball_y", 32'd236);       check(32'(dut.ball_y));
    expect_v("rst_scores", 32'd0);         check(32'({score_p1, score_p2}));
    expect_v("rst_winner_go", 32'd0);      check(32'({winner, game_over}));
    probe("col_ball", 12'd320, 12'd240, 3'b111);
    probe("col_pad1", 12'd18, 12'd220, 3'b001);
    probe("col_pad2", 12'd620, 12'd220, 3'b100);
    probe("col_border_l", 12'd0, 12'd100, 3'b010);
    probe("col_border_br", 12'd639, 12'd479, 3'b010);
    probe("col_bg", 12'd100, 12'd100, 3'b000);
    probe("col_offscreen", 12'd700, 12'd10, 3'b000);

    // Paddle 1 stepping and saturation at the top
    pulse(0); expect_v("pad1_up1", 32'd186); check(32'(dut.pad1_y));
    pulse(0); expect_v("pad1_up2", 32'd162); check(32'(dut.pad1_y));
    max_seen = 12'd0;
    for (int i = 0; i < 40; i++) begin
      pulse(0);
      if (dut.pad1_y > max_seen) max_seen = dut.pad1_y;
    end
    expect_v("pad1_sat", 32'd1);      check(32'(dut.pad1_y));
    expect_v("pad1_nowrap", 32'd138); check(32'(max_seen));

    // Rally: zone-0 hit on paddle 2, top-wall bounce, miss at paddle 1
    pulse(3); expect_v("pad2_down", 32'd234); check(32'(dut.pad2_y));
    pulse(4); expect_v("start_serve", 32'(ST_SERVE)); check(32'(dut.state));
    tick_wait(); expect_v("serve_hold", 32'(ST_SERVE)); check(32'(dut.state));
    tick_wait(); expect_v("serve_to_play", 32'(ST_PLAY)); check(32'(dut.state));
    expect_v("play_x0", 32'd316); check(32'(dut.ball_x));
    tick_wait(); expect_v("play_x1", 32'd320); check(32'(dut.ball_x));
    tick_wait(); expect_v("play_x2", 32'd324); check(32'(dut.ball_x));
    n = 0;
    while (dut.dir_right && n < 600) begin step(); n++; end
    expect_v("hit_seen", 32'd0); check(32'(dut.dir_right));
    expect_v("hit_snap_x", 32'd608); check(32'(dut.ball_x));
    expect_v("zone0_vxvy", 32'h22); check(32'({1'b0, dut.vx, 1'b0, dut.vy}));
    expect_v("zone0_up", 32'd0); check(32'(dut.dir_down));
    n = 0;
    while (!(dut.ball_y == 12'd2 && !dut.dir_down) && n < 800) begin step(); n++; end
    expect_v("top_pre_y", 32'd2); check(32'(dut.ball_y));
    tick_wait();
    expect_v("top_clamp_y", 32'd1); check(32'(dut.ball_y));
    expect_v("top_dir_down", 32'd1); check(32'(dut.dir_down));
    n = 0;
    while (score_p2 == 4'd0 && n < 2000) begin step(); n++; end
    expect_v("p2_scores", 32'h01); check(32'({score_p1, score_p2}));
    expect_v("point_state", 32'(ST_POINT)); check(32'(dut.state));
    probe("point_ball_hidden", 12'd320, 12'd240, 3'b000);
    tick_wait();
    expect_v("point_to_serve", 32'(ST_SERVE)); check(32'(dut.state));
    tick_wait();
    expect_v("serve_toward_p1", 32'd0); check(32'(dut.dir_right));

    // Reset mid-match, then a miss at paddle 2 parked at the top
    do_reset();
    expect_v("abort_state", 32'(ST_IDLE)); check(32'(dut.state));
    expect_v("abort_scores", 32'd0); check(32'({score_p1, score_p2}));
    repeat (12) pulse(2);
    expect_v("pad2_sat", 32'd1); check(32'(dut.pad2_y));
    pulse(4);
    n = 0;
    while (score_p1 == 4'd0 && n < 2000) begin step(); n++; end
    expect_v("p1_scores", 32'h10); check(32'({score_p1, score_p2}));
    expect_v("p1_point", 32'(ST_POINT)); check(32'(dut.state));
    tick_wait();
    tick_wait();
    expect_v("reserve_state", 32'(ST_SERVE)); check(32'(dut.state));
    expect_v("reserve_pos", 32'({12'd316, 12'd236})); check(32'({dut.ball_x, dut.ball_y}));
    expect_v("serve_toward_p2", 32'd1); check(32'(dut.dir_right));

    // Zone-4 hit, bottom-wall bounce
    do_reset();
    pulse(2); expect_v("pad2_up1", 32'd186); check(32'(dut.pad2_y));
    pulse(4);
    n = 0;
    while (dut.dir_right && n < 600) begin step(); n++; end
    expect_v("zone4_vxvy", 32'h22); check(32'({1'b0, dut.vx, 1'b0, dut.vy}));
    expect_v("zone4_down", 32'd1); check(32'(dut.dir_down));
    n = 0;
    while (!(dut.ball_y == 12'd470 && dut.dir_down) && n < 800) begin step(); n++; end
    expect_v("bot_pre_y", 32'd470); check(32'(dut.ball_y));
    tick_wait();
    expect_v("bot_clamp_y", 32'd471); check(32'(dut.ball_y));
    expect_v("bot_dir_up", 32'd0); check(32'(dut.dir_down));

    // Match to WIN_SCORE for player 2
    do_reset();
    repeat (12) pulse(0);
    pulse(4);
    n = 0;
    while (!game_over && n < 8000) begin step(); n++; end
    expect_v("over_flag", 32'd1); check(32'(game_over));
    expect_v("over_scores", 32'h09); check(32'({score_p1, score_p2}));
    expect_v("over_winner", 32'd2); check(32'(winner));
    expect_v("over_state", 32'(ST_OVER)); check(32'(dut.state));
    probe("over_ball_hidden", 12'd320, 12'd240, 3'b000);
    pulse(1); expect_v("over_pad1_down", 32'd25); check(32'(dut.pad1_y));
    pulse(0); expect_v("over_pad1_up", 32'd1); check(32'(dut.pad1_y));
    repeat (20) step();
    expect_v("over_frozen", 32'h09); check(32'({score_p1, score_p2}));
    pulse(4);
    expect_v("restart_scores", 32'd0); check(32'({score_p1, score_p2}));
    expect_v("restart_winner_go", 32'd0); check(32'({winner, game_over}));
    expect_v("restart_state", 32'(ST_SERVE)); check(32'(dut.state));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
